// File: rtl/io_pkg.sv
// Shared widths and FSM encodings for the io_unit keyboard/printer interface.
package io_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;

  typedef enum logic {
    InEmpty = 1'b0,
    InFull  = 1'b1
  } in_state_e;

  typedef enum logic {
    OutIdle = 1'b0,
    OutSend = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_fifo.sv
// Circular input buffer between the keyboard and INPR; only built when IO_FIFO_EN is defined.
`ifdef IO_FIFO_EN
module io_fifo
  import io_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign rd_data_o = mem_q[rptr_q];

  always_comb begin
    do_wr  = wr_en_i & ~full_o;
    do_rd  = rd_en_i & ~empty_o;
    wptr_d = do_wr ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_rd ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_wr) begin
        mem_q[wptr_q] <= wr_data_i;
      end
    end
  end

endmodule
`endif

// File: rtl/io_unit.sv
// Keyboard input register/flag and printer output register/flag with sticky protocol error.
// Define IO_FIFO_EN to insert a 4-entry FIFO between the keyboard and INPR.
module io_unit
  import io_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [DATA_W-1:0] KBD_DATA,
  input  logic              KBD_VALID,
  output logic              KBD_READY,
  output logic [DATA_W-1:0] INPR,
  input  logic              INP_ACK,
  output logic              FGI,
  input  logic [DATA_W-1:0] AC_LO,
  input  logic              OUT_LD,
  output logic [DATA_W-1:0] OUTR,
  output logic              PRN_VALID,
  input  logic              PRN_READY,
  output logic              FGO,
  output logic              ERR
);

  in_state_e         in_q, in_d;
  out_state_e        out_q, out_d;
  logic [DATA_W-1:0] inpr_q, inpr_d;
  logic [DATA_W-1:0] outr_q, outr_d;
  logic              err_q, err_d;
  logic              in_err, out_err;
  logic              load;
  logic [DATA_W-1:0] load_data;

`ifdef IO_FIFO_EN
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Reload INPR from the FIFO head whenever the flag is clear.
  assign load      = (in_q == InEmpty) & ~fifo_empty;
  assign load_data = fifo_head;
  assign KBD_READY = ~fifo_full;

  io_fifo u_fifo (
    .clk_i     (CLK),
    .rst_ni    (RSTn),
    .wr_en_i   (KBD_VALID),
    .wr_data_i (KBD_DATA),
    .rd_en_i   (load),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );
`else
  assign load      = (in_q == InEmpty) & KBD_VALID;
  assign load_data = KBD_DATA;
  assign KBD_READY = (in_q == InEmpty);
`endif

  always_comb begin
    in_d   = in_q;
    inpr_d = inpr_q;
    in_err = 1'b0;
    unique case (in_q)
      InEmpty: begin
        in_err = INP_ACK;
        if (load) begin
          inpr_d = load_data;
          in_d   = InFull;
        end
      end
      InFull: begin
        // Ack wins; a waiting character is only taken once back in InEmpty.
        if (INP_ACK) begin
          in_d = InEmpty;
        end
      end
      default: in_d = InEmpty;
    endcase
  end

  always_comb begin
    out_d   = out_q;
    outr_d  = outr_q;
    out_err = 1'b0;
    unique case (out_q)
      OutIdle: begin
        if (OUT_LD) begin
          outr_d = AC_LO;
          out_d  = OutSend;
        end
      end
      OutSend: begin
        out_err = OUT_LD;
        if (PRN_READY) begin
          out_d = OutIdle;
        end
      end
      default: out_d = OutIdle;
    endcase
  end

  assign err_d = err_q | in_err | out_err;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      in_q   <= InEmpty;
      out_q  <= OutIdle;
      inpr_q <= '0;
      outr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      in_q   <= in_d;
      out_q  <= out_d;
      inpr_q <= inpr_d;
      outr_q <= outr_d;
      err_q  <= err_d;
    end
  end

  assign FGI       = (in_q == InFull);
  assign INPR      = inpr_q;
  assign FGO       = (out_q == OutIdle);
  assign PRN_VALID = (out_q == OutSend);
  assign OUTR      = outr_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_io_unit.sv
// Scoreboard bench for io_unit: stimulus pushes expected characters, a monitor checks transfers.
module tb_io_unit;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [7:0] KBD_DATA;
  logic       KBD_VALID;
  logic       KBD_READY;
  logic [7:0] INPR;
  logic       INP_ACK;
  logic       FGI;
  logic [7:0] AC_LO;
  logic       OUT_LD;
  logic [7:0] OUTR;
  logic       PRN_VALID;
  logic       PRN_READY;
  logic       FGO;
  logic       ERR;

  int checks = 0;
  int errors = 0;
  logic [7:0] in_sb[$];
  logic [7:0] out_sb[$];
  logic fgi_prev = 1'b0;

  io_unit dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .KBD_DATA  (KBD_DATA),
    .KBD_VALID (KBD_VALID),
    .KBD_READY (KBD_READY),
    .INPR      (INPR),
    .INP_ACK   (INP_ACK),
    .FGI       (FGI),
    .AC_LO     (AC_LO),
    .OUT_LD    (OUT_LD),
    .OUTR      (OUTR),
    .PRN_VALID (PRN_VALID),
    .PRN_READY (PRN_READY),
    .FGO       (FGO),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_fgi"}, 32'(FGI), 32'd0);
    chk({tag, "_kbd_ready"}, 32'(KBD_READY), 32'd1);
    chk({tag, "_inpr"}, 32'(INPR), 32'h00);
    chk({tag, "_fgo"}, 32'(FGO), 32'd1);
    chk({tag, "_prn_valid"}, 32'(PRN_VALID), 32'd0);
    chk({tag, "_outr"}, 32'(OUTR), 32'h00);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    RSTn = 1'b0;
    in_sb.delete();
    out_sb.delete();
    #1;
    check_reset(tag);
    tick();
    RSTn = 1'b1;
    tick();
  endtask

  // Monitor: every new INPR character and every printer transfer is matched to the scoreboard.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (FGI && !fgi_prev) begin
        if (in_sb.size() == 0) chk("inpr_unexpected", 32'd1, 32'd0);
        else chk("inpr_sb", 32'(INPR), 32'(in_sb.pop_front()));
      end
      if (PRN_VALID && PRN_READY) begin
        if (out_sb.size() == 0) chk("outr_unexpected", 32'd1, 32'd0);
        else chk("outr_sb", 32'(OUTR), 32'(out_sb.pop_front()));
      end
    end
    fgi_prev <= FGI;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; KBD_DATA = '0; KBD_VALID = 1'b0; INP_ACK = 1'b0;
    AC_LO = '0; OUT_LD = 1'b0; PRN_READY = 1'b0;
    #2;
    check_reset("por");
    repeat (2) tick();
    RSTn = 1'b1;
    tick();

`ifndef IO_FIFO_EN
    // Single capture and ack.
    KBD_DATA = 8'h41; KBD_VALID = 1'b1; in_sb.push_back(8'h41);
    tick();
    KBD_VALID = 1'b0;
    chk("cap_fgi", 32'(FGI), 32'd1);
    chk("cap_inpr", 32'(INPR), 32'h41);
    chk("cap_kbd_ready", 32'(KBD_READY), 32'd0);
    tick();
    INP_ACK = 1'b1;
    tick();
    INP_ACK = 1'b0;
    chk("ack_fgi", 32'(FGI), 32'd0);
    chk("ack_kbd_ready", 32'(KBD_READY), 32'd1);
    chk("ack_err", 32'(ERR), 32'd0);

    // Ack and offered character in the same FULL cycle.
    KBD_DATA = 8'h10; KBD_VALID = 1'b1; in_sb.push_back(8'h10);
    tick();
    KBD_VALID = 1'b0;
    tick();
    KBD_DATA = 8'h42; KBD_VALID = 1'b1; INP_ACK = 1'b1; in_sb.push_back(8'h42);
    tick();
    INP_ACK = 1'b0;
    chk("race_fgi", 32'(FGI), 32'd0);
    chk("race_inpr_kept", 32'(INPR), 32'h10);
    tick();
    KBD_VALID = 1'b0;
    chk("race_fgi_next", 32'(FGI), 32'd1);
    chk("race_inpr_next", 32'(INPR), 32'h42);
    INP_ACK = 1'b1;
    tick();
    INP_ACK = 1'b0;
    chk("race_err", 32'(ERR), 32'd0);
`else
    // Five back-to-back writes fill INPR plus the 4-entry FIFO.
    for (int i = 1; i <= 5; i++) begin
      KBD_DATA = 8'(i); KBD_VALID = 1'b1; in_sb.push_back(8'(i));
      tick();
    end
    KBD_VALID = 1'b0;
    chk("fifo_inpr", 32'(INPR), 32'h01);
    chk("fifo_fgi", 32'(FGI), 32'd1);
    chk("fifo_full_ready", 32'(KBD_READY), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      INP_ACK = 1'b1;
      tick();
      INP_ACK = 1'b0;
      chk("fifo_gap_fgi", 32'(FGI), 32'd0);
      tick();
      chk("fifo_reload_fgi", 32'(FGI), 32'd1);
      chk("fifo_reload_inpr", 32'(INPR), 32'(i));
    end
    INP_ACK = 1'b1;
    tick();
    INP_ACK = 1'b0;
    tick();
    chk("fifo_drained_fgi", 32'(FGI), 32'd0);
    chk("fifo_drained_ready", 32'(KBD_READY), 32'd1);
    chk("fifo_err", 32'(ERR), 32'd0);
`endif

    // OUT with a stalled printer.
    AC_LO = 8'h5A; OUT_LD = 1'b1; out_sb.push_back(8'h5A);
    tick();
    OUT_LD = 1'b0; AC_LO = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("send_prn_valid", 32'(PRN_VALID), 32'd1);
      chk("send_outr", 32'(OUTR), 32'h5A);
      chk("send_fgo", 32'(FGO), 32'd0);
      tick();
    end
    PRN_READY = 1'b1;
    tick();
    PRN_READY = 1'b0;
    chk("done_fgo", 32'(FGO), 32'd1);
    chk("done_prn_valid", 32'(PRN_VALID), 32'd0);
    chk("done_err", 32'(ERR), 32'd0);

    // OUT while SEND, then OUT together with PRN_READY.
    AC_LO = 8'h5A; OUT_LD = 1'b1; out_sb.push_back(8'h5A);
    tick();
    AC_LO = 8'h33;
    tick();
    OUT_LD = 1'b0;
    chk("dup_outr", 32'(OUTR), 32'h5A);
    chk("dup_err", 32'(ERR), 32'd1);
    chk("dup_prn_valid", 32'(PRN_VALID), 32'd1);
    OUT_LD = 1'b1; PRN_READY = 1'b1;
    tick();
    OUT_LD = 1'b0; PRN_READY = 1'b0;
    chk("dup_rdy_fgo", 32'(FGO), 32'd1);
    chk("dup_rdy_outr", 32'(OUTR), 32'h5A);
    do_reset("rst1");

    // INP with nothing to read.
    INP_ACK = 1'b1;
    tick();
    INP_ACK = 1'b0;
    chk("bad_ack_err", 32'(ERR), 32'd1);
    chk("bad_ack_fgi", 32'(FGI), 32'd0);
    do_reset("rst2");

    // Both paths in the same cycle.
    KBD_DATA = 8'h77; KBD_VALID = 1'b1; in_sb.push_back(8'h77);
    AC_LO = 8'h88; OUT_LD = 1'b1; out_sb.push_back(8'h88);
    tick();
    KBD_VALID = 1'b0; OUT_LD = 1'b0;
`ifndef IO_FIFO_EN
    chk("both_fgi", 32'(FGI), 32'd1);
`endif
    chk("both_prn_valid", 32'(PRN_VALID), 32'd1);
    tick();
    chk("both_fgi_later", 32'(FGI), 32'd1);
    INP_ACK = 1'b1; PRN_READY = 1'b1;
    tick();
    INP_ACK = 1'b0; PRN_READY = 1'b0;
    chk("both_done_fgi", 32'(FGI), 32'd0);
    chk("both_done_fgo", 32'(FGO), 32'd1);
    chk("both_done_err", 32'(ERR), 32'd0);

    // Asynchronous reset in FULL and SEND, between clock edges.
    KBD_DATA = 8'h99; KBD_VALID = 1'b1; in_sb.push_back(8'h99);
    AC_LO = 8'h66; OUT_LD = 1'b1; out_sb.push_back(8'h66);
    tick();
    KBD_VALID = 1'b0; OUT_LD = 1'b0;
    repeat (2) tick();
    chk("pre_rst_fgi", 32'(FGI), 32'd1);
    chk("pre_rst_prn_valid", 32'(PRN_VALID), 32'd1);
    #5;
    RSTn = 1'b0;
    in_sb.delete();
    out_sb.delete();
    #1;
    check_reset("async");
    tick();
    RSTn = 1'b1;
    tick();
    tick();
    chk("post_rst_prn_valid", 32'(PRN_VALID), 32'd0);
    chk("in_sb_empty", 32'(in_sb.size()), 32'd0);
    chk("out_sb_empty", 32'(out_sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 CLK  input  1  single clock; all state updates on rising edge.
REQ-002 RSTn  input  1  reset, asynchronous, active-low.
REQ-003 KBD_DATA  input  8  character from input device.
REQ-004 KBD_VALID  input  1  device offers KBD_DATA; transfer when KBD_VALID & KBD_READY.
REQ-005 KBD_READY  output  1  unit can accept a character.
REQ-006 INPR  output  8  input register, read by CPU on INP.
REQ-007 INP_ACK  input  1  CPU executed INP; consumes INPR.
REQ-008 FGI  output  1  input flag, 1 = INPR holds unread character.
REQ-009 AC_LO  input  8  AC[7:0] from CPU.
REQ-010 OUT_LD  input  1  CPU executed OUT; load OUTR from AC_LO.
REQ-011 OUTR  output  8  output register, drives PRN_DATA.
REQ-012 PRN_VALID  output  1  OUTR offered to output device.
REQ-013 PRN_READY  input  1  device accepts; transfer when PRN_VALID & PRN_READY.
REQ-014 FGO  output  1  output flag, 1 = OUTR free for a new OUT.
REQ-015 ERR  output  1  sticky protocol error.

Function
REQ-016 Input FSM SHALL have states EMPTY (FGI=0) and FULL (FGI=1).
REQ-017 EMPTY: KBD_READY=1; on KBD_VALID, INPR<=KBD_DATA and go FULL next edge.
REQ-018 FULL: KBD_READY=0; INPR held; on INP_ACK, go EMPTY next edge; INPR value retained, not cleared.
REQ-019 INP_ACK and KBD_VALID in same FULL cycle: ack only, no capture; capture no earlier than the following cycle.
REQ-020 INP_ACK in EMPTY: no state change, ERR<=1.
REQ-021 Output FSM SHALL have states IDLE (FGO=1, PRN_VALID=0) and SEND (FGO=0, PRN_VALID=1).
REQ-022 IDLE: on OUT_LD, OUTR<=AC_LO, go SEND next edge.
REQ-023 SEND: OUTR and PRN_VALID held stable until PRN_READY; on PRN_READY go IDLE next edge, one transfer per OUT.
REQ-024 OUT_LD in SEND: ignored (OUTR unchanged), ERR<=1; OUT_LD with PRN_READY in same SEND cycle: still an error, transfer completes normally.
REQ-025 Input and output paths SHALL be fully independent; simultaneous events on both take effect in the same cycle.
REQ-026 All outputs SHALL be registered or decoded from state only; no combinational path from any input to any output.

Reset
REQ-027 RSTn low SHALL immediately force: input FSM EMPTY, FGI=0, KBD_READY=1, INPR=0, output FSM IDLE, FGO=1, PRN_VALID=0, OUTR=0, ERR=0.
REQ-028 Reset mid-transfer SHALL abandon the character without completing the handshake; ERR cleared only by reset.

Configuration
REQ-029 Macro IO_FIFO_EN SHALL enable a 4-entry input FIFO between device and INPR.
REQ-030 With IO_FIFO_EN: KBD_READY = FIFO not full; device writes go to FIFO; when FGI=0 and FIFO non-empty, head moves to INPR and FGI<=1 next edge; after INP_ACK, FGI stays 0 for exactly one cycle before reload; write and pop in same cycle on full FIFO allowed only if pop occurs (KBD_READY still 0 when full).
REQ-031 Without IO_FIFO_EN: single-register behaviour of REQ-016..REQ-020, no FIFO storage instantiated.

Structure
REQ-032 Shared package io_pkg SHALL hold DATA_W=8, FIFO_DEPTH=4, pointer width, and the input/output FSM state encodings.
REQ-033 FIFO SHALL be a sub-module io_fifo (circular buffer, wrap-around pointers, full/empty from count), instantiated only under IO_FIFO_EN.

Verification
REQ-034 Reset, then KBD_DATA=0x41 with KBD_VALID for 1 cycle -> next cycle FGI=1, INPR=0x41, KBD_READY=0; INP_ACK 1 cycle -> FGI=0, KBD_READY=1.
REQ-035 AC_LO=0x5A, OUT_LD 1 cycle, PRN_READY=0 for 5 cycles then 1 -> PRN_VALID=1 and OUTR=0x5A throughout, FGO=1 one cycle after PRN_READY.
REQ-036 Second OUT_LD with AC_LO=0x33 while SEND -> OUTR stays 0x5A, ERR=1; INP_ACK with FGI=0 -> ERR=1.
REQ-037 FULL with INP_ACK and KBD_VALID (0x42) same cycle -> FGI=0 next cycle, INPR unchanged, 0x42 captured the cycle after.
REQ-038 IO_FIFO_EN: 5 back-to-back writes 0x01..0x05 with no ack -> INPR=0x01, 4 in FIFO, KBD_READY=0; ack 5 times -> INPR sequence 0x02..0x05, order preserved across pointer wrap.
REQ-039 Assert RSTn low during SEND and FULL -> all outputs reach REQ-027 values without waiting for a clock edge.
